// File: rtl/iq_shift_ctrl_pkg.sv
// Shared definitions for the adaptive IQ truncation-shift controller:
// controller state encoding and the default shift-field width.
package iq_shift_ctrl_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        TRACK   = 2'd1,
        MANUAL  = 2'd2
    } state_t;

    localparam int DEF_MAX_SHIFT = 8;
    localparam int SHIFT_W       = $clog2(DEF_MAX_SHIFT + 1);

endpackage

// File: rtl/iq_shift_ctrl_if.sv
// Sample/config/output bundle of the IQ shift controller. The master side
// feeds wide samples and config; the slave side is the controller.
interface iq_shift_ctrl_if
    import iq_shift_ctrl_pkg::*;
#(
    parameter int IN_WIDTH = 24,
    parameter int O_WIDTH  = 16,
    parameter int SW       = SHIFT_W
);
    logic [2*IN_WIDTH-1:0] IQ_tdata;
    logic                  IQ_tvalid;
    logic                  cfg_manual;
    logic [SW-1:0]         cfg_shift;
    logic [O_WIDTH-1:0]    I_tdata;
    logic [O_WIDTH-1:0]    Q_tdata;
    logic                  I_tvalid;
    logic                  Q_tvalid;
    logic [SW-1:0]         shift;
    logic                  locked;
    logic                  sat;

    modport master (
        output IQ_tdata, IQ_tvalid, cfg_manual, cfg_shift,
        input  I_tdata, Q_tdata, I_tvalid, Q_tvalid, shift, locked, sat
    );

    modport slave (
        input  IQ_tdata, IQ_tvalid, cfg_manual, cfg_shift,
        output I_tdata, Q_tdata, I_tvalid, Q_tvalid, shift, locked, sat
    );

endinterface

// File: rtl/iq_shift_sat.sv
// Combinational arithmetic right-shift of one signed component followed by
// saturation to the signed output range.
module iq_shift_sat #(
    parameter int IN_WIDTH = 24,
    parameter int O_WIDTH  = 16,
    parameter int SW       = 4
) (
    input  logic signed [IN_WIDTH-1:0] x,
    input  logic        [SW-1:0]       s,
    output logic signed [O_WIDTH-1:0]  y,
    output logic                       clamped
);

    localparam logic signed [IN_WIDTH-1:0] HI = IN_WIDTH'((2 ** (O_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] LO = ~HI;

    logic signed [IN_WIDTH-1:0] shifted;

    always_comb begin
        shifted = x >>> s;
        clamped = 1'b0;
        y       = shifted[O_WIDTH-1:0];
        if (shifted > HI) begin
            y       = HI[O_WIDTH-1:0];
            clamped = 1'b1;
        end else if (shifted < LO) begin
            y       = LO[O_WIDTH-1:0];
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/iq_shift_ctrl.sv
// Adaptive truncation-shift controller: tracks the peak I/Q magnitude per
// window, adjusts the right-shift with hysteresis, and saturates the output.
module iq_shift_ctrl
    import iq_shift_ctrl_pkg::*;
#(
    parameter int IN_WIDTH     = 24,
    parameter int O_WIDTH      = 16,
    parameter int WINDOW_LOG2  = 10,
    parameter int MAX_SHIFT    = 8,
    parameter int INIT_SHIFT   = 4,
    parameter int HOLD_WINDOWS = 4,
    parameter int LOCK_WINDOWS = 2
) (
    input logic             clk,
    input logic             rst,
    iq_shift_ctrl_if.slave  io
);

    localparam int SW    = $clog2(MAX_SHIFT + 1);
    localparam int CNT_W = 8;

    localparam logic [SW-1:0]    MAX_S   = SW'(MAX_SHIFT);
    localparam logic [SW-1:0]    INIT_S  = SW'(INIT_SHIFT);
    localparam logic [CNT_W-1:0] LOCK_N  = CNT_W'(LOCK_WINDOWS);
    localparam logic [CNT_W-1:0] HOLD_N  = CNT_W'(HOLD_WINDOWS);
    localparam logic [IN_WIDTH:0] THR_ONE = (IN_WIDTH + 1)'(1);

    function automatic logic [IN_WIDTH-1:0] abs_val(input logic [IN_WIDTH-1:0] v);
        return v[IN_WIDTH-1] ? (~v + 1'b1) : v;
    endfunction

    logic signed [IN_WIDTH-1:0] in_i, in_q;
    logic signed [O_WIDTH-1:0]  y_i, y_q;
    logic                       clamp_i, clamp_q;
    logic [IN_WIDTH-1:0]        mag_i, mag_q, sample_mag, pk_next;
    logic [IN_WIDTH:0]          over_thr, under_thr;
    logic                       over, under;
    logic [SW-1:0]              cfg_clamped;

    state_t                     state_q, state_d;
    logic [SW-1:0]              shift_q, shift_d;
    logic                       locked_q, locked_d;
    logic [CNT_W-1:0]           stable_q, stable_d;
    logic [CNT_W-1:0]           hold_q, hold_d;
    logic [WINDOW_LOG2-1:0]     cnt_q, cnt_d;
    logic [IN_WIDTH-1:0]        peak_q, peak_d;
    logic [IN_WIDTH-1:0]        pk_final_q, pk_final_d;
    logic                       eow_q, eow_d;
    logic [O_WIDTH-1:0]         i_q, i_d, q_q, q_d;
    logic                       valid_q, valid_d;
    logic                       sat_q, sat_d;

    assign in_i = io.IQ_tdata[2*IN_WIDTH-1:IN_WIDTH];
    assign in_q = io.IQ_tdata[IN_WIDTH-1:0];

    iq_shift_sat #(.IN_WIDTH(IN_WIDTH), .O_WIDTH(O_WIDTH), .SW(SW)) u_sat_i (
        .x(in_i), .s(shift_q), .y(y_i), .clamped(clamp_i)
    );

    iq_shift_sat #(.IN_WIDTH(IN_WIDTH), .O_WIDTH(O_WIDTH), .SW(SW)) u_sat_q (
        .x(in_q), .s(shift_q), .y(y_q), .clamped(clamp_q)
    );

    // Thresholds are one bit wider so 2**(IN_WIDTH-1) compares exactly.
    always_comb begin
        mag_i       = abs_val(in_i);
        mag_q       = abs_val(in_q);
        sample_mag  = (mag_i > mag_q) ? mag_i : mag_q;
        pk_next     = (sample_mag > peak_q) ? sample_mag : peak_q;
        over_thr    = THR_ONE << (O_WIDTH - 1 + int'(shift_q));
        under_thr   = THR_ONE << (O_WIDTH - 3 + int'(shift_q));
        over        = ({1'b0, pk_final_q} >= over_thr);
        under       = ({1'b0, pk_final_q} <  under_thr);
        cfg_clamped = (io.cfg_shift > MAX_S) ? MAX_S : io.cfg_shift;
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        stable_d   = stable_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        peak_d     = peak_q;
        pk_final_d = pk_final_q;
        eow_d      = 1'b0;
        i_d        = i_q;
        q_d        = q_q;
        valid_d    = 1'b0;
        sat_d      = 1'b0;

        if (io.IQ_tvalid) begin
            i_d     = y_i;
            q_d     = y_q;
            valid_d = 1'b1;
            sat_d   = clamp_i | clamp_q;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == '1) begin
                eow_d      = 1'b1;
                pk_final_d = pk_next;
                peak_d     = '0;
            end else begin
                peak_d     = pk_next;
            end
        end

        // The end-of-window decision lands one cycle after the last sample.
        if (io.cfg_manual) begin
            state_d  = MANUAL;
            shift_d  = cfg_clamped;
            stable_d = '0;
            hold_d   = '0;
        end else begin
            case (state_q)
                MANUAL: state_d = ACQUIRE;
                ACQUIRE: if (eow_q) begin
                    if (over && shift_q != MAX_S) begin
                        shift_d  = shift_q + 1'b1;
                        stable_d = '0;
                    end else if (under && shift_q != '0) begin
                        shift_d  = shift_q - 1'b1;
                        stable_d = '0;
                    end else if (stable_q + 1'b1 >= LOCK_N) begin
                        state_d  = TRACK;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end
                TRACK: if (eow_q) begin
                    if (over) begin
                        hold_d = '0;
                        if (shift_q != MAX_S) begin
                            shift_d = shift_q + 1'b1;
                            state_d = ACQUIRE;
                        end
                    end else if (under) begin
                        if (hold_q + 1'b1 >= HOLD_N) begin
                            hold_d = '0;
                            if (shift_q != '0) shift_d = shift_q - 1'b1;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end else begin
                        hold_d = '0;
                    end
                end
                default: state_d = ACQUIRE;
            endcase
        end

        locked_d = (state_d == TRACK);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ACQUIRE;
            shift_q    <= INIT_S;
            locked_q   <= 1'b0;
            stable_q   <= '0;
            hold_q     <= '0;
            cnt_q      <= '0;
            peak_q     <= '0;
            pk_final_q <= '0;
            eow_q      <= 1'b0;
            i_q        <= '0;
            q_q        <= '0;
            valid_q    <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            locked_q   <= locked_d;
            stable_q   <= stable_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            peak_q     <= peak_d;
            pk_final_q <= pk_final_d;
            eow_q      <= eow_d;
            i_q        <= i_d;
            q_q        <= q_d;
            valid_q    <= valid_d;
            sat_q      <= sat_d;
        end
    end

    assign io.I_tdata  = i_q;
    assign io.Q_tdata  = q_q;
    assign io.I_tvalid = valid_q;
    assign io.Q_tvalid = valid_q;
    assign io.shift    = shift_q;
    assign io.locked   = locked_q;
    assign io.sat      = sat_q;

endmodule

// File: tb/tb_iq_shift_ctrl.sv
// Randomized bench for iq_shift_ctrl (16-sample windows) checked against a
// sample-level behavioural model of the shift controller.
module tb_iq_shift_ctrl;

    localparam int WIN  = 16;
    localparam int MAXS = 8;
    localparam int FULL = 8388607;
    localparam int NEGF = -8388608;

    logic clk;
    logic rst;

    iq_shift_ctrl_if #(.IN_WIDTH(24), .O_WIDTH(16), .SW(4)) bus();

    iq_shift_ctrl #(
        .IN_WIDTH(24), .O_WIDTH(16), .WINDOW_LOG2(4), .MAX_SHIFT(8),
        .INIT_SHIFT(4), .HOLD_WINDOWS(4), .LOCK_WINDOWS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(bus.slave)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state: mode 0=acquire, 1=track, 2=manual
    int     mS, mMode, mStable, mHold, mCnt;
    longint mPeak, mPendPeak;
    bit     mPend;
    int     eI, eQ;
    bit     eV, eSat;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint magOf(input int x);
        return (x < 0) ? -longint'(x) : longint'(x);
    endfunction

    function automatic int satModel(input int x, input int s, output bit c);
        int y;
        y = x / (1 << s);
        if (x < 0 && (x % (1 << s)) != 0) y = y - 1;
        c = 1'b0;
        if (y > 32767)  begin y = 32767;  c = 1'b1; end
        if (y < -32768) begin y = -32768; c = 1'b1; end
        return y;
    endfunction

    function automatic void modelReset();
        mS = 4; mMode = 0; mStable = 0; mHold = 0; mCnt = 0;
        mPeak = 0; mPendPeak = 0; mPend = 1'b0;
        eV = 1'b0; eSat = 1'b0; eI = 0; eQ = 0;
    endfunction

    function automatic void modelStep(input bit v, input int i, input int q, input bit m, input int cs);
        bit ci, cq, over, under;
        int ns;
        longint smag;
        eV = v;
        eSat = 1'b0;
        if (v) begin
            eI = satModel(i, mS, ci);
            eQ = satModel(q, mS, cq);
            eSat = ci | cq;
        end
        if (m) begin
            mS = (cs > MAXS) ? MAXS : cs;
            mMode = 2; mStable = 0; mHold = 0;
        end else if (mMode == 2) begin
            mMode = 0;
        end else if (mPend) begin
            over  = mPendPeak >= (longint'(1) << (15 + mS));
            under = mPendPeak <  (longint'(1) << (13 + mS));
            if (mMode == 0) begin
                ns = over ? ((mS < MAXS) ? mS + 1 : mS) : under ? ((mS > 0) ? mS - 1 : 0) : mS;
                if (ns == mS) begin
                    mStable++;
                    if (mStable >= 2) begin mMode = 1; mStable = 0; end
                end else begin
                    mStable = 0;
                end
                mS = ns;
            end else begin
                if (over) begin
                    if (mS < MAXS) begin mS++; mMode = 0; end
                    mHold = 0;
                end else if (under) begin
                    mHold++;
                    if (mHold >= 4) begin
                        if (mS > 0) mS--;
                        mHold = 0;
                    end
                end else begin
                    mHold = 0;
                end
            end
        end
        mPend = 1'b0;
        if (v) begin
            smag = (magOf(i) > magOf(q)) ? magOf(i) : magOf(q);
            if (smag > mPeak) mPeak = smag;
            mCnt++;
            if (mCnt == WIN) begin
                mPend = 1'b1; mPendPeak = mPeak; mPeak = 0; mCnt = 0;
            end
        end
    endfunction

    // One clock of stimulus, followed by a check against the model.
    task automatic applyStimulus(input bit v, input int i, input int q, input bit m, input int cs);
        logic [31:0] ti, tq, tc;
        ti = i; tq = q; tc = cs;
        bus.IQ_tvalid  = v;
        bus.IQ_tdata   = {ti[23:0], tq[23:0]};
        bus.cfg_manual = m;
        bus.cfg_shift  = tc[3:0];
        @(posedge clk);
        modelStep(v, i, q, m, cs);
        #1;
        checkOutput("shift", bus.shift, mS);
        checkOutput("locked", bus.locked, (mMode == 1));
        checkOutput("I_tvalid", bus.I_tvalid, eV);
        checkOutput("Q_tvalid", bus.Q_tvalid, eV);
        if (eV) begin
            checkOutput("I_tdata", $signed(bus.I_tdata), eI);
            checkOutput("Q_tdata", $signed(bus.Q_tdata), eQ);
            checkOutput("sat", bus.sat, eSat);
        end
    endtask

    task automatic doReset();
        bus.IQ_tvalid = 1'b0;
        bus.cfg_manual = 1'b0;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("rst_shift", bus.shift, 4);
        checkOutput("rst_locked", bus.locked, 0);
        checkOutput("rst_I", bus.I_tdata, 0);
        checkOutput("rst_valid", bus.I_tvalid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int amp, vi, vq, manLeft, cs;
        bit man;
        rst = 1'b0;
        bus.IQ_tdata = '0; bus.IQ_tvalid = 1'b0;
        bus.cfg_manual = 1'b0; bus.cfg_shift = '0;
        modelReset();
        @(posedge clk); #1;
        doReset();
        checkOutput("reset_Q", bus.Q_tdata, 0);

        // Full-scale positive: shift climbs to 8 then locks
        for (int k = 0; k < 100; k++) applyStimulus(1'b1, FULL, FULL, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        checkOutput("ramp_shift", bus.shift, 8);
        checkOutput("ramp_locked", bus.locked, 1);
        applyStimulus(1'b1, FULL, FULL, 1'b0, 0);
        checkOutput("ramp_I", $signed(bus.I_tdata), 32767);
        checkOutput("ramp_sat", bus.sat, 0);

        // Most negative input while pinned at the maximum shift
        for (int k = 0; k < 40; k++) applyStimulus(1'b1, NEGF, 0, 1'b0, 0);
        checkOutput("neg_I", $signed(bus.I_tdata), -32768);
        checkOutput("neg_sat", bus.sat, 0);
        checkOutput("neg_shift", bus.shift, 8);
        checkOutput("neg_locked", bus.locked, 1);

        // Small signal: shift walks down to 0 then locks
        doReset();
        for (int k = 0; k < 100; k++) applyStimulus(1'b1, 1000, 0, 1'b0, 0);
        checkOutput("small_shift", bus.shift, 0);
        checkOutput("small_locked", bus.locked, 1);
        checkOutput("small_I", $signed(bus.I_tdata), 1000);

        // Manual override with clamping
        applyStimulus(1'b0, 0, 0, 1'b1, 0);
        applyStimulus(1'b1, 40000, -40000, 1'b1, 0);
        checkOutput("man_I", $signed(bus.I_tdata), 32767);
        checkOutput("man_Q", $signed(bus.Q_tdata), -32768);
        checkOutput("man_sat", bus.sat, 1);
        checkOutput("man_locked", bus.locked, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 15);
        checkOutput("man_clamp", bus.shift, 8);

        // Randomized traffic with gaps, amplitude changes and manual bursts
        amp = 20; manLeft = 0; man = 1'b0; cs = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k % 48 == 0) amp = $urandom_range(23, 0);
            if (manLeft > 0) manLeft--;
            else if ($urandom_range(199, 0) == 0) begin
                manLeft = $urandom_range(30, 5);
                cs = $urandom_range(15, 0);
            end
            man = (manLeft > 0);
            vi = $urandom_range((1 << amp) - 1, 0);
            vq = $urandom_range((1 << amp) - 1, 0);
            if ($urandom_range(1, 0) == 1) vi = -vi;
            if ($urandom_range(1, 0) == 1) vq = -vq;
            if (amp == 23 && $urandom_range(15, 0) == 0) vi = NEGF;
            applyStimulus($urandom_range(3, 0) != 0, vi, vq, man, man ? cs : $urandom_range(15, 0));
        end

        // Reset mid-window discards the partial window
        doReset();
        for (int k = 0; k < 7; k++) applyStimulus(1'b1, FULL, FULL, 1'b0, 0);
        doReset();
        checkOutput("midrst_shift", bus.shift, 4);
        for (int k = 0; k < 15; k++) applyStimulus(1'b1, FULL, FULL, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        checkOutput("win15_shift", bus.shift, 4);
        applyStimulus(1'b1, FULL, FULL, 1'b0, 0);
        checkOutput("win16_shift", bus.shift, 4);
        applyStimulus(1'b0, 0, 0, 1'b0, 0);
        checkOutput("win16_update", bus.shift, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
